osd_dem_uart_16550_fifo: RTL

- Next-generation 16550-compatible bus frontend for the UART debug module.
- Adds parametrised RX/TX FIFOs, FCR trigger levels, self-clearing FIFO reset bits, and SCR/MCR storage.
- Registers bus accesses with a one-cycle acknowledge.
- Sits between the CPU-side 16550 register bus and the ready/valid character streams consumed by osd_dem_uart.

---
 rtl/osd_dem_uart_16550_pkg.sv | 38 +++
 rtl/osd_dem_uart_fifo.sv | 59 +++++
 rtl/osd_dem_uart_16550_fifo.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/osd_dem_uart_16550_pkg.sv
// Shared definitions for the 16550-compatible UART bus frontend:
// register indices, IIR identification codes, LSR bit positions,
// the FCR receive trigger encoding and the IER layout.
package osd_dem_uart_16550_pkg;

    localparam logic [2:0] REG_RBR_THR = 3'd0;
    localparam logic [2:0] REG_IER     = 3'd1;
    localparam logic [2:0] REG_IIR_FCR = 3'd2;
    localparam logic [2:0] REG_LCR     = 3'd3;
    localparam logic [2:0] REG_MCR     = 3'd4;
    localparam logic [2:0] REG_LSR     = 3'd5;
    localparam logic [2:0] REG_MSR     = 3'd6;
    localparam logic [2:0] REG_SCR     = 3'd7;

    localparam logic [3:0] IIR_LS   = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_TO   = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;
    localparam logic [3:0] IIR_NONE = 4'b0001;

    localparam int LSR_DR   = 0;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    typedef enum logic [1:0] {
        TRIG_ONE       = 2'b00,
        TRIG_QUARTER   = 2'b01,
        TRIG_HALF      = 2'b10,
        TRIG_NEAR_FULL = 2'b11
    } fcr_trig_e;

    typedef struct packed {
        logic elsi;
        logic etbei;
        logic erbfi;
    } ier_t;

endpackage

// File: rtl/osd_dem_uart_fifo.sv
// Circular-buffer FIFO with flush and a capacity limit input that
// shrinks the usable depth to a single entry (16450 compatibility).
// A pop and a push in the same cycle on a full FIFO are both honoured.
module osd_dem_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             limit_one,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign count   = count_reg;
    assign empty   = (count_reg == '0);
    assign full    = limit_one ? (count_reg != '0) : (count_reg == CW'(DEPTH));
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop) & ~flush;

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/osd_dem_uart_16550_fifo.sv
// 16550-compatible register frontend with RX/TX FIFOs for the UART
// debug module. Bus accesses are acknowledged one cycle after acceptance.
// Optional feature macro: OSD_DEM_UART_16550_RX_TIMEOUT_EN adds the
// receive character-timeout interrupt (IIR code 1100).
module osd_dem_uart_16550_fifo
    import osd_dem_uart_16550_pkg::*;
#(
    parameter int TX_FIFO_DEPTH     = 16,
    parameter int RX_FIFO_DEPTH     = 16,
    parameter int RX_TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_req,
    input  logic [2:0] bus_addr,
    input  logic       bus_write,
    input  logic [7:0] bus_wdata,
    output logic       bus_ack,
    output logic [7:0] bus_rdata,
    input  logic       drop,
    output logic       out_valid,
    output logic [7:0] out_char,
    input  logic       out_ready,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       irq
);

    localparam int TX_CW = $clog2(TX_FIFO_DEPTH + 1);
    localparam int RX_CW = $clog2(RX_FIFO_DEPTH + 1);

    ier_t      ier_reg;
    logic [7:0] lcr_reg;
    logic [4:0] mcr_reg;
    logic [7:0] scr_reg;
    logic [7:0] dll_reg;
    logic [7:0] dlm_reg;
    logic       fifo_en_reg;
    fcr_trig_e  trig_reg;
    logic       ack_reg;
    logic [7:0] rdata_reg;
    logic [7:0] rdata_next;

    logic             accept, dlab, is_wr, is_rd;
    logic             thr_push, rbr_pop, fcr_wr, mode_change;
    logic             tx_flush, rx_flush, tx_pop, rx_push;
    logic [TX_CW-1:0] tx_count;
    logic [RX_CW-1:0] rx_count;
    logic [RX_CW-1:0] trigger;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]       tx_head, rx_head;
    logic             irq_rda, irq_thre, irq_ls, irq_to;
    logic [3:0]       iir_id;
    logic [7:0]       iir, lsr;
    logic [TX_CW-1:0] unused_tx_count;

    assign accept      = bus_req & ~ack_reg;
    assign dlab        = lcr_reg[7];
    assign is_wr       = accept & bus_write;
    assign is_rd       = accept & ~bus_write;
    assign thr_push    = is_wr & (bus_addr == REG_RBR_THR) & ~dlab;
    assign rbr_pop     = is_rd & (bus_addr == REG_RBR_THR) & ~dlab;
    assign fcr_wr      = is_wr & (bus_addr == REG_IIR_FCR);
    assign mode_change = fcr_wr & (bus_wdata[0] != fifo_en_reg);
    assign rx_flush    = fcr_wr & (bus_wdata[1] | mode_change);
    assign tx_flush    = fcr_wr & (bus_wdata[2] | mode_change);

    assign out_valid = ~tx_empty;
    assign out_char  = tx_head;
    assign tx_pop    = out_valid & (out_ready | drop);
    assign in_ready  = ~rx_full & rst_n;
    assign rx_push   = in_valid & in_ready;
    assign unused_tx_count = tx_count;

    osd_dem_uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (tx_flush),
        .limit_one (~fifo_en_reg),
        .push      (thr_push),
        .din       (bus_wdata),
        .pop       (tx_pop),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    osd_dem_uart_fifo #(.DEPTH(RX_FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (rx_flush),
        .limit_one (~fifo_en_reg),
        .push      (rx_push),
        .din       (in_char),
        .pop       (rbr_pop),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

`ifdef OSD_DEM_UART_16550_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(RX_TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            rx_popped;

    assign rx_popped = rbr_pop & ~rx_empty;
    assign irq_to    = ier_reg.erbfi & (to_cnt_reg == TO_W'(RX_TIMEOUT_CYCLES));

    // Idle counter: restarts on any RX activity or while RX is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg <= '0;
        end else if (rx_push | rx_popped | rx_empty) begin
            to_cnt_reg <= '0;
        end else if (to_cnt_reg != TO_W'(RX_TIMEOUT_CYCLES)) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (RX_TIMEOUT_CYCLES == 0);
    assign irq_to = 1'b0;
`endif

    // Receive trigger level; 16450 mode always triggers on one character.
    always_comb begin
        trigger = RX_CW'(1);
        if (fifo_en_reg) begin
            case (trig_reg)
                TRIG_QUARTER:   trigger = RX_CW'(RX_FIFO_DEPTH / 4);
                TRIG_HALF:      trigger = RX_CW'(RX_FIFO_DEPTH / 2);
                TRIG_NEAR_FULL: trigger = RX_CW'(RX_FIFO_DEPTH - 2);
                default:        trigger = RX_CW'(1);
            endcase
        end
    end

    assign irq_rda  = ier_reg.erbfi & (rx_count >= trigger);
    assign irq_thre = ier_reg.etbei & tx_empty;
    assign irq_ls   = 1'b0;
    assign irq      = irq_rda | irq_thre | irq_ls | irq_to;

    // Interrupt identification by fixed priority.
    always_comb begin
        if (irq_ls)        iir_id = IIR_LS;
        else if (irq_rda)  iir_id = IIR_RDA;
        else if (irq_to)   iir_id = IIR_TO;
        else if (irq_thre) iir_id = IIR_THRE;
        else               iir_id = IIR_NONE;
    end

    assign iir = {fifo_en_reg, fifo_en_reg, 2'b00, iir_id};

    always_comb begin
        lsr           = 8'h00;
        lsr[LSR_DR]   = ~rx_empty;
        lsr[LSR_THRE] = tx_empty;
        lsr[LSR_TEMT] = tx_empty & ~out_valid;
    end

    // Read data multiplexer, sampled into the ack register at acceptance.
    always_comb begin
        rdata_next = 8'h00;
        case (bus_addr)
            REG_RBR_THR: rdata_next = dlab ? dll_reg : (rx_empty ? 8'h00 : rx_head);
            REG_IER:     rdata_next = dlab ? dlm_reg : {5'b0, ier_reg};
            REG_IIR_FCR: rdata_next = iir;
            REG_LCR:     rdata_next = lcr_reg;
            REG_MCR:     rdata_next = {3'b0, mcr_reg};
            REG_LSR:     rdata_next = lsr;
            REG_MSR:     rdata_next = 8'h00;
            REG_SCR:     rdata_next = scr_reg;
            default:     rdata_next = 8'h00;
        endcase
    end

    // Bus acknowledge, read data capture and register writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg     <= 1'b0;
            rdata_reg   <= 8'h00;
            ier_reg     <= '0;
            lcr_reg     <= 8'h00;
            mcr_reg     <= 5'h00;
            scr_reg     <= 8'h00;
            dll_reg     <= 8'h00;
            dlm_reg     <= 8'h00;
            fifo_en_reg <= 1'b0;
            trig_reg    <= TRIG_ONE;
        end else begin
            ack_reg <= accept;
            if (is_rd) rdata_reg <= rdata_next;
            else if (accept) rdata_reg <= 8'h00;
            if (is_wr) begin
                case (bus_addr)
                    REG_RBR_THR: if (dlab) dll_reg <= bus_wdata;
                    REG_IER: begin
                        if (dlab) dlm_reg <= bus_wdata;
                        else      ier_reg <= ier_t'(bus_wdata[2:0]);
                    end
                    REG_IIR_FCR: begin
                        fifo_en_reg <= bus_wdata[0];
                        trig_reg    <= fcr_trig_e'(bus_wdata[7:6]);
                    end
                    REG_LCR: lcr_reg <= bus_wdata;
                    REG_MCR: mcr_reg <= bus_wdata[4:0];
                    REG_SCR: scr_reg <= bus_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign bus_ack   = ack_reg;
    assign bus_rdata = rdata_reg;

endmodule
